// File: rtl/spike_encoder.sv
// spike_encoder
//   Integrate-and-fire input encoder. Each transaction loads one vector of
//   unsigned activations and emits a spike train over num_steps timesteps.
//   Each lane spikes floor(N*x/thr) times. With thr == 0, every lane spikes
//   on every step.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      input vector offered
//   in_ready      encoder idle and accepting (low while rst is high)
//   in_data       lane i at [i*DATA_WIDTH +: DATA_WIDTH], unsigned
//   threshold     shared firing threshold, sampled with in_data
//   num_steps     number of timesteps to emit, sampled with in_data
//   spike_valid   current timestep's spike vector valid
//   spike_ready   downstream accepts the spike vector
//   spikes        one spike bit per lane
//   timestep      0-based index of the current timestep
//   spike_last    current timestep is the final one
module spike_encoder #(
    parameter int NUM_LANES   = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMER_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0]           threshold,
    input  logic [TIMER_WIDTH-1:0]          num_steps,
    output logic                            spike_valid,
    input  logic                            spike_ready,
    output logic [NUM_LANES-1:0]            spikes,
    output logic [TIMER_WIDTH-1:0]          timestep,
    output logic                            spike_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   thr;
    logic [TIMER_WIDTH-1:0]  n_steps;
    logic [TIMER_WIDTH-1:0]  step;
    logic [DATA_WIDTH-1:0]   acc     [NUM_LANES];
    logic [DATA_WIDTH-1:0]   x       [NUM_LANES];
    logic [DATA_WIDTH-1:0]   lane_in [NUM_LANES];
    logic [DATA_WIDTH:0]     sum     [NUM_LANES];
    logic [NUM_LANES-1:0]    fire_vec;
    logic                    hit_last;
    logic                    load;
    logic                    fire;

    // One extra bit on the sum: acc < thr and x <= thr, so it never overflows.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_in[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sum[i]      = {1'b0, acc[i]} + {1'b0, x[i]};
            fire_vec[i] = (sum[i] >= {1'b0, thr});
        end
    end

    assign hit_last = (step == n_steps - TIMER_WIDTH'(1));
    assign load     = in_valid && in_ready;
    assign fire     = spike_valid && spike_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        spike_valid = 1'b0;
        spikes      = '0;
        timestep    = '0;
        spike_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                // A zero-length transaction is absorbed without leaving IDLE.
                if (in_valid && !rst && num_steps != '0) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                spike_valid = 1'b1;
                spikes      = fire_vec;
                timestep    = step;
                spike_last  = hit_last;
                if (spike_ready && hit_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr     <= '0;
            n_steps <= '0;
            step    <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                acc[i] <= '0;
                x[i]   <= '0;
            end
        end else if (load) begin
            thr     <= threshold;
            n_steps <= num_steps;
            step    <= '0;
            // Clamping x to thr keeps acc < thr after every step.
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                acc[i] <= '0;
                x[i]   <= (lane_in[i] < threshold) ? lane_in[i] : threshold;
            end
        end else if (fire) begin
            step <= step + TIMER_WIDTH'(1);
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                acc[i] <= fire_vec[i] ? DATA_WIDTH'(sum[i] - {1'b0, thr})
                                      : DATA_WIDTH'(sum[i]);
            end
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: directed transactions with a
// scoreboard of expected spike vectors, checked at each handshake.
module tb_spike_encoder;

    localparam int NL = 3;
    localparam int DW = 16;
    localparam int TW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NL*DW-1:0] in_data;
    logic [DW-1:0]    threshold;
    logic [TW-1:0]    num_steps;
    logic             spike_valid;
    logic             spike_ready;
    logic [NL-1:0]    spikes;
    logic [TW-1:0]    timestep;
    logic             spike_last;

    spike_encoder #(
        .NUM_LANES   (NL),
        .DATA_WIDTH  (DW),
        .TIMER_WIDTH (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .threshold   (threshold),
        .num_steps   (num_steps),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spikes      (spikes),
        .timestep    (timestep),
        .spike_last  (spike_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] spk;
        logic [TW-1:0] ts;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cnt  [NL];
    logic [31:0]   mask [NL];
    logic [NL-1:0] last_spk;
    int            ncyc;
    bit            done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_count(input int n, input int xr, input int thr);
        int xc;
        xc = (xr < thr) ? xr : thr;
        return (thr == 0) ? n : (n * xc) / thr;
    endfunction

    task automatic load(input int x0, input int x1, input int x2, input int thr, input int n);
        int   xs  [NL];
        int   acc [NL];
        int   s;
        exp_t e;
        xs = '{x0, x1, x2};
        in_valid  = 1'b1;
        in_data   = {DW'(x2), DW'(x1), DW'(x0)};
        threshold = DW'(thr);
        num_steps = TW'(n);
        chk("load_in_ready", in_ready, 1);
        for (int i = 0; i < NL; i++) begin
            acc[i] = 0;
            if (xs[i] > thr) xs[i] = thr;
        end
        for (int st = 0; st < n; st++) begin
            for (int i = 0; i < NL; i++) begin
                s = acc[i] + xs[i];
                e.spk[i] = (s >= thr);
                acc[i] = (s >= thr) ? s - thr : s;
            end
            e.ts   = TW'(st);
            e.last = (st == n - 1);
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        if (n == 0) begin
            chk("n0_in_ready", in_ready, 1);
            chk("n0_valid", spike_valid, 0);
        end else begin
            chk("load_valid", spike_valid, 1);
        end
    endtask

    task automatic drain(input bit bp, input int stop_at, output int cycles, output bit fin);
        int            ticks  = 0;
        bit            stalled = 1'b0;
        logic [NL-1:0] s_spk;
        logic [TW-1:0] s_ts;
        logic          s_last;
        exp_t          e;
        fin = 1'b0;
        for (int i = 0; i < NL; i++) begin
            cnt[i]  = 0;
            mask[i] = '0;
        end
        while (!fin && ticks < 200) begin
            if (stalled) begin
                chk("stall_spikes", spikes, s_spk);
                chk("stall_timestep", timestep, s_ts);
                chk("stall_last", spike_last, s_last);
                stalled = 1'b0;
            end
            if (spike_valid && stop_at >= 0 && int'(timestep) == stop_at) begin
                fin = 1'b1;
                break;
            end
            spike_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spike_valid) begin
                chk("busy_in_ready", in_ready, 0);
                in_data   = (NL*DW)'({$urandom, $urandom});
                threshold = DW'($urandom);
                num_steps = TW'($urandom);
                in_valid  = 1'($urandom_range(0, 1));
                if (spike_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("spikes", spikes, e.spk);
                        chk("timestep", timestep, e.ts);
                        chk("spike_last", spike_last, e.last);
                    end
                    for (int i = 0; i < NL; i++) begin
                        if (spikes[i]) begin
                            cnt[i]++;
                            mask[i][timestep] = 1'b1;
                        end
                    end
                    last_spk = spikes;
                    if (spike_last) begin
                        fin = 1'b1;
                        in_valid = 1'b0;
                    end
                end else begin
                    stalled = 1'b1;
                    s_spk   = spikes;
                    s_ts    = timestep;
                    s_last  = spike_last;
                end
            end
            tick();
            ticks++;
        end
        in_valid = 1'b0;
        cycles = ticks + 1;
        if (!fin) chk("drain_timeout", 0, 1);
        if (fin && stop_at < 0) begin
            chk("post_in_ready", in_ready, 1);
            chk("post_valid", spike_valid, 0);
        end
    endtask

    task automatic check_txn(input int x0, input int x1, input int x2, input int thr,
                             input int n, input logic [31:0] m0, input logic [31:0] m1,
                             input logic [31:0] m2);
        chk("count0", cnt[0], exp_count(n, x0, thr));
        chk("count1", cnt[1], exp_count(n, x1, thr));
        chk("count2", cnt[2], exp_count(n, x2, thr));
        chk("mask0", mask[0], m0);
        chk("mask1", mask[1], m1);
        chk("mask2", mask[2], m2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        spike_ready = 1'b0;
        in_data     = '0;
        threshold   = '0;
        num_steps   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", spike_valid, 0);
        chk("rst_spikes", spikes, 0);
        chk("rst_timestep", timestep, 0);
        chk("rst_last", spike_last, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Basic counts, full throughput
        load(3, 5, 10, 10, 10);
        drain(1'b0, -1, ncyc, done);
        chk("basic_cycles", ncyc, 11);
        check_txn(3, 5, 10, 10, 10, 32'h248, 32'h2AA, 32'h3FF);

        // Same vector under random backpressure
        load(3, 5, 10, 10, 10);
        drain(1'b1, -1, ncyc, done);
        check_txn(3, 5, 10, 10, 10, 32'h248, 32'h2AA, 32'h3FF);

        // Clamp and zero
        load(20, 0, 9, 10, 4);
        drain(1'b0, -1, ncyc, done);
        check_txn(20, 0, 9, 10, 4, 32'hF, 32'h0, 32'hE);

        // N = 0: nothing emitted, always ready
        load(7, 7, 7, 5, 0);
        repeat (3) begin
            tick();
            chk("n0_idle_valid", spike_valid, 0);
            chk("n0_idle_ready", in_ready, 1);
        end

        // N = 31 maximum
        load(1, 30, 31, 31, 31);
        drain(1'b1, -1, ncyc, done);
        check_txn(1, 30, 31, 31, 31, 32'h40000000, 32'h7FFFFFFE, 32'h7FFFFFFF);
        chk("n31_last_lane0", last_spk[0], 1);

        // Reset mid-run at step 4
        load(3, 5, 10, 10, 10);
        drain(1'b0, 4, ncyc, done);
        chk("abort_reached", done, 1);
        rst = 1'b1;
        tick();
        chk("abort_valid", spike_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_timestep", timestep, 0);
        sb.delete();
        rst = 1'b0;
        #1;
        chk("abort_rel_ready", in_ready, 1);
        tick();
        chk("abort_idle_valid", spike_valid, 0);
        load(3, 7, 1, 10, 10);
        drain(1'b0, -1, ncyc, done);
        check_txn(3, 7, 1, 10, 10, 32'h248, 32'h3B6, 32'h200);

        // thr = 0: all lanes fire every step
        load(5, 0, 65535, 0, 6);
        drain(1'b1, -1, ncyc, done);
        check_txn(5, 0, 65535, 0, 6, 32'h3F, 32'h3F, 32'h3F);

        chk("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Integrate-and-fire input encoder for the spiking array. It is the transmit-side counterpart of the activation stage: it takes one vector of unsigned multi-bit activations per transaction and converts each lane into a deterministic spike train over a programmable number of timesteps. It sits between the input buffer and the first row of the array. Over N timesteps, each lane's spike count equals the value the downstream activation stage is expected to accumulate.

## Interface

- NUM_LANES, 3, number of parallel lanes
- DATA_WIDTH, 16, activation and threshold width (unsigned)
- TIMER_WIDTH, 5, timestep counter width

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input vector offered
- in_ready  output  1  encoder idle and accepting a vector
- in_data  input  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], unsigned
- threshold  input  DATA_WIDTH  firing threshold shared by all lanes, unsigned; sampled with in_data
- num_steps  input  TIMER_WIDTH  timesteps to emit; sampled with in_data
- spike_valid  output  1  current timestep's spike vector valid
- spike_ready  input  1  downstream accepts the spike vector
- spikes  output  NUM_LANES  one spike bit per lane for the current timestep
- timestep  output  TIMER_WIDTH  index of the current timestep, 0-based
- spike_last  output  1  current timestep is the final one of the transaction

## Operation

- Two-state FSM: IDLE and RUN.
- In IDLE, in_ready=1 and spike_valid=0.
- Load occurs when in_valid && in_ready:
  - thr <= threshold; N <= num_steps; step <= 0; acc_i <= 0.
  - x_i <= min(in_data_i, threshold); this clamp keeps the invariant acc_i < thr.
  - If num_steps==0, remain in IDLE and emit nothing. Otherwise go to RUN.
- In RUN, in_ready=0 and spike_valid=1.
- Outputs in RUN are combinational from registers and stay stable while stalled:
  - sum_i = acc_i + x_i, computed at DATA_WIDTH+1 bits with no overflow possible.
  - spikes[i] = (sum_i >= thr).
  - timestep = step.
  - spike_last = (step == N-1).
- On spike_valid && spike_ready:
  - acc_i <= spikes[i] ? sum_i - thr : sum_i.
  - step <= step+1.
  - If spike_last, go to IDLE.
- With no handshake, all state holds.
- Resulting count per lane = floor(N*x_i/thr). With thr=0, every lane spikes on every step.
- No overlap: a new vector is never accepted during RUN. Inputs other than those sampled at load are ignored.

## Timing

- Reset (rst high at an edge), from the next cycle:
  - state=IDLE, acc=0, step=0.
  - spike_valid=0, spikes=0, timestep=0, spike_last=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Reset mid-RUN aborts the transaction. spike_valid=0 the cycle after the reset edge, no further spikes from the aborted vector, and the next load starts from step 0 with acc 0.
- Load accepted at edge k gives spike_valid=1 from cycle k+1.
- One timestep per cycle when spike_ready is held high. A transaction takes N+1 cycles, load to next in_ready.
- in_ready returns to 1 in the cycle after the spike_last handshake.
- num_steps==0: in_ready stays 1 through the load, and spike_valid never rises.
- Max N = 2^TIMER_WIDTH-1 (31). The step counter never wraps within a transaction.

## Test plan

- Basic counts: thr=10, x={3,5,10}, N=10, spike_ready=1.
  - Lane0 spikes at steps 3,6,9.
  - Lane1 spikes at steps 1,3,5,7,9.
  - Lane2 spikes every step; counts {3,5,10}.
  - spike_last only at step 9; in_ready=1 at cycle 11 after the load.
- Backpressure: same vector with spike_ready toggled pseudo-randomly.
  - Identical spike sequence to the basic case.
  - spikes, timestep and spike_last stable while spike_valid && !spike_ready.
- Clamp and zero: thr=10, x={20,0,9}, N=4.
  - Lane0 spikes on all 4 steps; lane1 never spikes.
  - Lane2 spikes at steps 1,2,3 (acc 9→8→7→6).
- Boundary steps:
  - N=0 gives no spike_valid and in_ready continuously 1.
  - N=31, thr=31, x={1,30,31} gives counts {1,30,31}; lane0's single spike is at step 30, concurrent with spike_last.
- Reset mid-run: N=10, assert rst at step 4.
  - spike_valid=0 the next cycle, in_ready=1 after rst drops.
  - A new load of x={3,..} restarts at timestep 0 with lane0's first spike at step 3.
- thr=0: any x gives spikes=all-ones on every one of N steps.
